// File: rtl/period_generator_amisha_pkg.sv
// Shared definitions for the period generator.
// Contents: FSM state encoding (idle/high/low/done), default 1 ms prescale count,
//   and a helper that sizes counters so that a count of 1 still gets one bit.
package period_generator_amisha_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HIGH = 2'b01,
    ST_LOW  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // 50 MHz system clock -> 50000 cycles per millisecond
  localparam int DEF_CLK_MS_COUNT = 50000;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/period_generator_amisha_if.sv
// Request/status bundle of the period generator.
// Signals: start_amisha/stop_amisha requests, prd_amisha (ms) and n_amisha (period
//   count) arguments driven by the master; sq_out_amisha, ready_amisha,
//   done_tick_amisha and err_amisha returned by the generator (slave).
interface period_generator_amisha_if #(
  parameter int PRD_W = 10,
  parameter int N_W   = 4
);
  logic             start_amisha;
  logic             stop_amisha;
  logic [PRD_W-1:0] prd_amisha;
  logic [N_W-1:0]   n_amisha;
  logic             sq_out_amisha;
  logic             ready_amisha;
  logic             done_tick_amisha;
  logic             err_amisha;

  modport master (
    output start_amisha, stop_amisha, prd_amisha, n_amisha,
    input  sq_out_amisha, ready_amisha, done_tick_amisha, err_amisha
  );

  modport slave (
    input  start_amisha, stop_amisha, prd_amisha, n_amisha,
    output sq_out_amisha, ready_amisha, done_tick_amisha, err_amisha
  );
endinterface

// File: rtl/period_generator_amisha_ms_tick_gen.sv
// Millisecond prescaler.
// Ports: clk_amisha / reset_amisha (async, active-low); clr synchronously returns the
//   prescaler to 0; en lets it count 0..CLK_MS_COUNT-1; ms_tick is high for the one
//   cycle the prescaler sits at its terminal value while enabled.
module period_generator_amisha_ms_tick_gen
  import period_generator_amisha_pkg::*;
#(
  parameter int CLK_MS_COUNT = DEF_CLK_MS_COUNT
) (
  input  logic clk_amisha,
  input  logic reset_amisha,
  input  logic clr,
  input  logic en,
  output logic ms_tick
);
  localparam int W = cnt_w(CLK_MS_COUNT);
  localparam logic [W-1:0] TERM = W'(CLK_MS_COUNT - 1);

  logic [W-1:0] presc_q, presc_d;

  always_comb begin
    presc_d = presc_q;
    if (clr)
      presc_d = '0;
    else if (en)
      presc_d = (presc_q == TERM) ? '0 : presc_q + W'(1);
  end

  always_ff @(posedge clk_amisha or negedge reset_amisha) begin
    if (!reset_amisha) presc_q <= '0;
    else               presc_q <= presc_d;
  end

  assign ms_tick = en && !clr && (presc_q == TERM);
endmodule

// File: rtl/period_generator_amisha.sv
// Square-wave period generator (FSMD).
// Produces prd_amisha ms periods on sq_out_amisha, n_amisha times, after an accepted
// start. High half = floor(prd/2) ms, low half = the remainder, so odd periods have
// the longer low phase. stop_amisha aborts a run; prd<2 or n=0 is rejected with
// err_amisha. Ports: clk_amisha, reset_amisha (async, active-low), bus (slave modport).
module period_generator_amisha
  import period_generator_amisha_pkg::*;
#(
  parameter int CLK_MS_COUNT = DEF_CLK_MS_COUNT,
  parameter int PRD_W        = 10,
  parameter int N_W          = 4
) (
  input  logic                     clk_amisha,
  input  logic                     reset_amisha,
  period_generator_amisha_if.slave bus
);
  state_e           state_q, state_d;
  logic [PRD_W-1:0] prd_q, prd_d;
  logic [PRD_W-1:0] ms_cnt_q, ms_cnt_d;
  logic [N_W-1:0]   n_rem_q, n_rem_d;
  logic             sq_q, sq_d;
  logic             err_q, err_d;

  logic             ms_tick;
  logic             accept;
  logic             busy;
  logic [PRD_W-1:0] high_ms, low_ms, ms_nxt;

  assign accept  = (state_q == ST_IDLE) && bus.start_amisha;
  assign busy    = (state_q == ST_HIGH) || (state_q == ST_LOW);
  assign high_ms = prd_q >> 1;
  assign low_ms  = prd_q - high_ms;
  assign ms_nxt  = ms_cnt_q + PRD_W'(1);

  // Prescaler restarts on every accepted start so the first high phase is full length
  period_generator_amisha_ms_tick_gen #(.CLK_MS_COUNT(CLK_MS_COUNT)) u_tick (
    .clk_amisha   (clk_amisha),
    .reset_amisha (reset_amisha),
    .clr          (accept),
    .en           (busy),
    .ms_tick      (ms_tick)
  );

  always_comb begin
    state_d  = state_q;
    prd_d    = prd_q;
    ms_cnt_d = ms_cnt_q;
    n_rem_d  = n_rem_q;
    sq_d     = sq_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_amisha) begin
          prd_d    = bus.prd_amisha;
          n_rem_d  = bus.n_amisha;
          ms_cnt_d = '0;
          if ((bus.prd_amisha < PRD_W'(2)) || (bus.n_amisha == '0)) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = ST_HIGH;
            err_d   = 1'b0;
            sq_d    = 1'b1;
          end
        end
      end
      ST_HIGH: begin
        // abort takes priority over a coincident ms tick
        if (bus.stop_amisha) begin
          state_d  = ST_DONE;
          sq_d     = 1'b0;
          ms_cnt_d = '0;
        end else if (ms_tick) begin
          if (ms_nxt == high_ms) begin
            state_d  = ST_LOW;
            sq_d     = 1'b0;
            ms_cnt_d = '0;
          end else begin
            ms_cnt_d = ms_nxt;
          end
        end
      end
      ST_LOW: begin
        if (bus.stop_amisha) begin
          state_d  = ST_DONE;
          sq_d     = 1'b0;
          ms_cnt_d = '0;
        end else if (ms_tick) begin
          if (ms_nxt == low_ms) begin
            ms_cnt_d = '0;
            n_rem_d  = n_rem_q - N_W'(1);
            if (n_rem_q == N_W'(1)) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_HIGH;
              sq_d    = 1'b1;
            end
          end else begin
            ms_cnt_d = ms_nxt;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_amisha or negedge reset_amisha) begin
    if (!reset_amisha) begin
      state_q  <= ST_IDLE;
      prd_q    <= '0;
      ms_cnt_q <= '0;
      n_rem_q  <= '0;
      sq_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prd_q    <= prd_d;
      ms_cnt_q <= ms_cnt_d;
      n_rem_q  <= n_rem_d;
      sq_q     <= sq_d;
      err_q    <= err_d;
    end
  end

  // Status outputs are decoded from flops only, never from inputs
  assign bus.sq_out_amisha    = sq_q;
  assign bus.ready_amisha     = (state_q == ST_IDLE);
  assign bus.done_tick_amisha = (state_q == ST_DONE);
  assign bus.err_amisha       = err_q;
endmodule
